mips_wb_stage: RTL and testbench
================================

Name: mips_wb_stage

Overview:
- Write-back stage of the 5-stage MIPS pipeline: the writer side of the register-file port that the decode stage reads.
- Holds a MEM/WB pipeline register with a valid/ready handshake toward MEM.
- Aligns and extends load data, selects the ALU result or the load result, and drives the register-file write port (WR/WD/WriteReg).
- Exposes a forwarding tap for the hazard unit and stalls MEM when the register-file write port is withheld.

Parameters:
- REG_AW, 5, register address width.
- DATA_W, 32, datapath width; only 32 is supported.
- CNT_W, 32, width of the retire counter (optional feature only).

Ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  asynchronous, active-low reset.
- mem_valid  in  1  MEM stage presents an instruction.
- mem_ready  out  1  WB can accept this cycle.
- mem_reg_write  in  1  instruction writes a register.
- mem_to_reg  in  1  1 = load result, 0 = ALU result.
- mem_rd  in  REG_AW  destination register.
- mem_alu_result  in  DATA_W  ALU result, or load address for loads.
- mem_load_data  in  DATA_W  raw word read from data memory.
- mem_load_type  in  3  LT_LW/LT_LH/LT_LHU/LT_LB/LT_LBU.
- rf_wr_ready  in  1  register-file write port is available this cycle.
- rf_we  out  1  register-file write enable (drives WriteReg).
- rf_wa  out  REG_AW  write address (drives WR).
- rf_wd  out  DATA_W  write data (drives WD).
- fwd_valid  out  1  WB holds a pending write, usable for forwarding.
- fwd_rd  out  REG_AW  forwarding destination register.
- fwd_data  out  DATA_W  forwarding data; equals rf_wd.
- align_err  out  1  one-cycle pulse: a misaligned load was dropped.

Behaviour:
- Reset (rst=0, asynchronous): all of the following are cleared.
  - wb_valid=0 and every pipeline field = 0.
  - rf_we=0, rf_wa=0, rf_wd=0.
  - fwd_valid=0, fwd_rd=0, fwd_data=0, align_err=0.
  - mem_ready=1 while wb_valid=0.
  - Any pending write is discarded; it is never replayed.
- Accept: at a clk edge with mem_valid && mem_ready, all mem_* inputs are registered and wb_valid is set.
  - Latency: one cycle from acceptance to rf_we.
- needs_write = wb_valid && reg_write && (rd != 0) && !misaligned.
- rf_we = needs_write && rf_wr_ready (combinational). $0 is never written.
- retire = wb_valid && (!needs_write || rf_wr_ready).
- mem_ready = !wb_valid || retire. This gives full throughput: accept and retire can happen on the same edge.
- Stall: while wb_valid && needs_write && !rf_wr_ready:
  - all pipeline fields hold;
  - rf_wa and rf_wd stay stable;
  - fwd_valid stays 1.
- Load alignment is little-endian on mem_alu_result[1:0]:
  - LT_LW: the whole word; requires [1:0] = 0.
  - LT_LH / LT_LHU: halfword selected by [1], sign- or zero-extended; requires [0] = 0.
  - LT_LB / LT_LBU: byte [1:0], sign- or zero-extended.
  - Unknown encodings behave as LT_LW.
- Misaligned load (mem_to_reg=1 and the alignment rule is violated):
  - the write is suppressed;
  - the entry retires in the cycle it becomes valid;
  - align_err=1 for exactly that cycle.
- rf_wd = mem_to_reg ? aligned load : alu_result.
- rf_wa = rd whenever wb_valid=1; otherwise 0.
- fwd_valid = needs_write, regardless of rf_wr_ready.
- Same-cycle bypass of write-then-read to one register is the register file's concern, not this block's.

Optional Feature:
- Macro: MIPS_WB_RETIRE_CNT_EN.
- Defined:
  - adds output retire_cnt (CNT_W bits);
  - reset to 0;
  - +1 on every retire edge, including suppressed writes, $0 destinations and misaligned loads;
  - wraps from all-ones to 0.
- Undefined: the port and the counter are absent, and the rest of the behaviour is identical.

Decomposition:
- Package mips_pkg holds:
  - the LT_* load-type localparams (LT_LW=0, LT_LH=1, LT_LHU=2, LT_LB=3, LT_LBU=4);
  - REG_ZERO=5'd0.
- Sub-module mips_load_align (purely combinational): inputs raw word, addr[1:0] and type; outputs the aligned word and a misaligned flag.

Test Plan:
- ALU write: mem_valid=1, reg_write=1, mem_to_reg=0, rd=8, alu=0x1234_5678, rf_wr_ready=1 -> next cycle rf_we=1, rf_wa=8, rf_wd=0x1234_5678, mem_ready=1.
- Load extension: data=0x80FF_7F01, addr lo=2, LT_LH -> rf_wd=0xFFFF_80FF; LT_LHU -> 0x0000_80FF; LT_LB with addr lo=1 -> 0x0000_007F.
- Stall: rf_wr_ready=0 for 3 cycles with a second instruction waiting -> mem_ready=0, rf_wa/rf_wd/fwd_* held for 3 cycles; write on the 4th edge; second instruction accepted on that same edge.
- $0 / misaligned: rd=0 -> rf_we never asserts and the entry retires. LT_LW with addr lo=1, rd=5 -> rf_we=0, align_err high for 1 cycle.
- Reset mid-stall: drop rst while stalled -> all outputs 0 immediately; after release, mem_ready=1 and no stale write appears.
- With MIPS_WB_RETIRE_CNT_EN defined: 10 back-to-back instructions, one of them misaligned -> retire_cnt=10. Preload the counter to all-ones and retire one more -> retire_cnt=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline: load-type encodings and the hard-wired
// zero register index.
package mips_pkg;

  typedef enum logic [2:0] {
    LT_LW  = 3'd0,
    LT_LH  = 3'd1,
    LT_LHU = 3'd2,
    LT_LB  = 3'd3,
    LT_LBU = 3'd4
  } load_type_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/mips_wb_stage_if.sv
// MEM->WB handshake, register-file write port and forwarding tap of the WB stage.
interface mips_wb_stage_if #(
  parameter int REG_AW = 5,
  parameter int DATA_W = 32
);

  logic              mem_valid;
  logic              mem_ready;
  logic              mem_reg_write;
  logic              mem_to_reg;
  logic [REG_AW-1:0] mem_rd;
  logic [DATA_W-1:0] mem_alu_result;
  logic [DATA_W-1:0] mem_load_data;
  logic [2:0]        mem_load_type;
  logic              rf_wr_ready;
  logic              rf_we;
  logic [REG_AW-1:0] rf_wa;
  logic [DATA_W-1:0] rf_wd;
  logic              fwd_valid;
  logic [REG_AW-1:0] fwd_rd;
  logic [DATA_W-1:0] fwd_data;
  logic              align_err;

  modport master (
    output mem_valid, mem_reg_write, mem_to_reg, mem_rd, mem_alu_result,
           mem_load_data, mem_load_type, rf_wr_ready,
    input  mem_ready, rf_we, rf_wa, rf_wd, fwd_valid, fwd_rd, fwd_data, align_err
  );

  modport slave (
    input  mem_valid, mem_reg_write, mem_to_reg, mem_rd, mem_alu_result,
           mem_load_data, mem_load_type, rf_wr_ready,
    output mem_ready, rf_we, rf_wa, rf_wd, fwd_valid, fwd_rd, fwd_data, align_err
  );

endinterface

// File: rtl/mips_load_align.sv
// Little-endian load alignment and sign/zero extension; flags misaligned accesses.
module mips_load_align
  import mips_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  load_type,
  output logic [31:0] data,
  output logic        misaligned
);

  logic [15:0] half_v;
  logic [7:0]  byte_v;

  always_comb begin
    half_v = addr_lo[1] ? raw[31:16] : raw[15:0];
    unique case (addr_lo)
      2'd0:    byte_v = raw[7:0];
      2'd1:    byte_v = raw[15:8];
      2'd2:    byte_v = raw[23:16];
      default: byte_v = raw[31:24];
    endcase
  end

  // Unknown encodings fall through to the word path.
  always_comb begin
    data       = raw;
    misaligned = (addr_lo != 2'b00);
    case (load_type)
      LT_LH: begin
        data       = {{16{half_v[15]}}, half_v};
        misaligned = addr_lo[0];
      end
      LT_LHU: begin
        data       = {16'h0000, half_v};
        misaligned = addr_lo[0];
      end
      LT_LB: begin
        data       = {{24{byte_v[7]}}, byte_v};
        misaligned = 1'b0;
      end
      LT_LBU: begin
        data       = {24'h000000, byte_v};
        misaligned = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_wb_stage.sv
// MIPS write-back stage: MEM/WB register, load alignment, register-file write port.
// Optional retire counter enabled by defining MIPS_WB_RETIRE_CNT_EN.
module mips_wb_stage
  import mips_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  mips_wb_stage_if.slave   bus
`ifdef MIPS_WB_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0] retire_cnt
`endif
);

  logic              wb_valid_q, wb_valid_d;
  logic              reg_write_q, reg_write_d;
  logic              to_reg_q, to_reg_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] load_q, load_d;
  logic [2:0]        lt_q, lt_d;

  logic [31:0]       aligned;
  logic              lt_misaligned;
  logic              misaligned;
  logic              needs_write;
  logic              retire;
  logic              accept;
  logic [DATA_W-1:0] wd;

  mips_load_align u_align (
    .raw        (load_q),
    .addr_lo    (alu_q[1:0]),
    .load_type  (lt_q),
    .data       (aligned),
    .misaligned (lt_misaligned)
  );

  always_comb begin
    misaligned  = to_reg_q && lt_misaligned;
    needs_write = wb_valid_q && reg_write_q && (rd_q != REG_AW'(REG_ZERO)) && !misaligned;
    retire      = wb_valid_q && (!needs_write || bus.rf_wr_ready);
    accept      = bus.mem_valid && bus.mem_ready;
    wd          = to_reg_q ? aligned : alu_q;

    bus.mem_ready = !wb_valid_q || retire;
    bus.rf_we     = needs_write && bus.rf_wr_ready;
    bus.rf_wa     = wb_valid_q ? rd_q : '0;
    bus.rf_wd     = wb_valid_q ? wd : '0;
    bus.fwd_valid = needs_write;
    bus.fwd_rd    = bus.rf_wa;
    bus.fwd_data  = bus.rf_wd;
    bus.align_err = wb_valid_q && misaligned;
  end

  always_comb begin
    wb_valid_d  = wb_valid_q;
    reg_write_d = reg_write_q;
    to_reg_d    = to_reg_q;
    rd_d        = rd_q;
    alu_d       = alu_q;
    load_d      = load_q;
    lt_d        = lt_q;
    if (accept) begin
      wb_valid_d  = 1'b1;
      reg_write_d = bus.mem_reg_write;
      to_reg_d    = bus.mem_to_reg;
      rd_d        = bus.mem_rd;
      alu_d       = bus.mem_alu_result;
      load_d      = bus.mem_load_data;
      lt_d        = bus.mem_load_type;
    end else if (retire) begin
      wb_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid_q  <= 1'b0;
      reg_write_q <= 1'b0;
      to_reg_q    <= 1'b0;
      rd_q        <= '0;
      alu_q       <= '0;
      load_q      <= '0;
      lt_q        <= '0;
    end else begin
      wb_valid_q  <= wb_valid_d;
      reg_write_q <= reg_write_d;
      to_reg_q    <= to_reg_d;
      rd_q        <= rd_d;
      alu_q       <= alu_d;
      load_q      <= load_d;
      lt_q        <= lt_d;
    end
  end

`ifdef MIPS_WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

  always_comb begin
    retire_cnt_d = retire ? retire_cnt_q + CNT_W'(1) : retire_cnt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) retire_cnt_q <= '0;
    else      retire_cnt_q <= retire_cnt_d;
  end

  assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_mips_wb_stage.sv
// Directed bench for mips_wb_stage: vector table plus stall, reset and misalign sequences.
module tb_mips_wb_stage;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  mips_wb_stage_if #(.REG_AW(5), .DATA_W(32)) bus ();

`ifdef MIPS_WB_RETIRE_CNT_EN
  logic [3:0] retire_cnt;
  mips_wb_stage #(.REG_AW(5), .DATA_W(32), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .bus(bus), .retire_cnt(retire_cnt)
  );
`else
  mips_wb_stage #(.REG_AW(5), .DATA_W(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic        tr;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] ld;
    logic [2:0]  lt;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        fv;
    logic        ae;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rw, input logic tr, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] ld, input logic [2:0] lt);
    bus.mem_reg_write  = rw;
    bus.mem_to_reg     = tr;
    bus.mem_rd         = rd;
    bus.mem_alu_result = alu;
    bus.mem_load_data  = ld;
    bus.mem_load_type  = lt;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".rf_we"},     32'(bus.rf_we),     32'd0);
    check({tag, ".rf_wa"},     32'(bus.rf_wa),     32'd0);
    check({tag, ".rf_wd"},     bus.rf_wd,          32'd0);
    check({tag, ".fwd_valid"}, 32'(bus.fwd_valid), 32'd0);
    check({tag, ".fwd_rd"},    32'(bus.fwd_rd),    32'd0);
    check({tag, ".fwd_data"},  bus.fwd_data,       32'd0);
    check({tag, ".align_err"}, 32'(bus.align_err), 32'd0);
    check({tag, ".mem_ready"}, 32'(bus.mem_ready), 32'd1);
  endtask

  initial begin
    //           rw tr rd     alu            load           lt      we wa     wd             fv ae
    vecs[0]  = '{1, 0, 5'd8,  32'h1234_5678, 32'h0,         LT_LW,  1, 5'd8,  32'h1234_5678, 1, 0};
    vecs[1]  = '{1, 1, 5'd3,  32'h0000_1002, 32'h80FF_7F01, LT_LH,  1, 5'd3,  32'hFFFF_80FF, 1, 0};
    vecs[2]  = '{1, 1, 5'd4,  32'h0000_1002, 32'h80FF_7F01, LT_LHU, 1, 5'd4,  32'h0000_80FF, 1, 0};
    vecs[3]  = '{1, 1, 5'd6,  32'h0000_1001, 32'h80FF_7F01, LT_LB,  1, 5'd6,  32'h0000_007F, 1, 0};
    vecs[4]  = '{1, 1, 5'd7,  32'h0000_1003, 32'h80FF_7F01, LT_LB,  1, 5'd7,  32'hFFFF_FF80, 1, 0};
    vecs[5]  = '{1, 1, 5'd9,  32'h0000_1000, 32'hDEAD_BEEF, LT_LW,  1, 5'd9,  32'hDEAD_BEEF, 1, 0};
    vecs[6]  = '{1, 0, 5'd0,  32'hAAAA_5555, 32'h0,         LT_LW,  0, 5'd0,  32'hAAAA_5555, 0, 0};
    vecs[7]  = '{1, 1, 5'd5,  32'h0000_1001, 32'h1122_3344, LT_LW,  0, 5'd5,  32'h1122_3344, 0, 1};
    vecs[8]  = '{1, 1, 5'd10, 32'h0000_1001, 32'h1122_3344, LT_LH,  0, 5'd10, 32'h0000_3344, 0, 1};
    vecs[9]  = '{0, 0, 5'd12, 32'h0000_0005, 32'h0,         LT_LW,  0, 5'd12, 32'h0000_0005, 0, 0};
    vecs[10] = '{1, 1, 5'd13, 32'h0000_2000, 32'hABCD_0123, 3'd7,   1, 5'd13, 32'hABCD_0123, 1, 0};
    vecs[11] = '{1, 1, 5'd14, 32'h0000_1002, 32'h80FF_7F01, LT_LBU, 1, 5'd14, 32'h0000_00FF, 1, 0};
    vecs[12] = '{1, 1, 5'd15, 32'h0000_1002, 32'h80FF_7F01, LT_LB,  1, 5'd15, 32'hFFFF_FFFF, 1, 0};
    vecs[13] = '{1, 1, 5'd16, 32'h0000_1000, 32'h80FF_7F01, LT_LHU, 1, 5'd16, 32'h0000_7F01, 1, 0};

    bus.mem_valid   = 1'b0;
    bus.rf_wr_ready = 1'b1;
    drive(0, 0, 5'd0, 32'h0, 32'h0, LT_LW);

    // Reset state
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;

    // Table-driven single instructions
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(vecs[i].rw, vecs[i].tr, vecs[i].rd, vecs[i].alu, vecs[i].ld, vecs[i].lt);
      bus.mem_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.mem_valid = 1'b0;
      check($sformatf("v%0d.rf_we", i),     32'(bus.rf_we),     32'(vecs[i].we));
      check($sformatf("v%0d.rf_wa", i),     32'(bus.rf_wa),     32'(vecs[i].wa));
      check($sformatf("v%0d.rf_wd", i),     bus.rf_wd,          vecs[i].wd);
      check($sformatf("v%0d.fwd_valid", i), 32'(bus.fwd_valid), 32'(vecs[i].fv));
      check($sformatf("v%0d.fwd_rd", i),    32'(bus.fwd_rd),    32'(vecs[i].wa));
      check($sformatf("v%0d.fwd_data", i),  bus.fwd_data,       vecs[i].wd);
      check($sformatf("v%0d.align_err", i), 32'(bus.align_err), 32'(vecs[i].ae));
      check($sformatf("v%0d.mem_ready", i), 32'(bus.mem_ready), 32'd1);
      @(posedge clk);
    end

    // align_err is a single-cycle pulse
    @(negedge clk);
    drive(1, 1, 5'd5, 32'h0000_1001, 32'h1122_3344, LT_LW);
    bus.mem_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_valid = 1'b0;
    check("mis.align_err_hi", 32'(bus.align_err), 32'd1);
    check("mis.rf_we",        32'(bus.rf_we),     32'd0);
    @(posedge clk);
    #1;
    check("mis.align_err_lo", 32'(bus.align_err), 32'd0);

    // Stall for three cycles with a second instruction waiting
    @(negedge clk);
    drive(1, 0, 5'd8, 32'h0000_0011, 32'h0, LT_LW);
    bus.rf_wr_ready = 1'b0;
    bus.mem_valid   = 1'b1;
    @(posedge clk);
    #1;
    drive(1, 0, 5'd9, 32'h0000_0022, 32'h0, LT_LW);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("stall%0d.mem_ready", c), 32'(bus.mem_ready), 32'd0);
      check($sformatf("stall%0d.rf_we", c),     32'(bus.rf_we),     32'd0);
      check($sformatf("stall%0d.rf_wa", c),     32'(bus.rf_wa),     32'd8);
      check($sformatf("stall%0d.rf_wd", c),     bus.rf_wd,          32'h11);
      check($sformatf("stall%0d.fwd_valid", c), 32'(bus.fwd_valid), 32'd1);
      check($sformatf("stall%0d.fwd_data", c),  bus.fwd_data,       32'h11);
    end
    bus.rf_wr_ready = 1'b1;
    #1;
    check("release.rf_we",     32'(bus.rf_we),     32'd1);
    check("release.mem_ready", 32'(bus.mem_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.mem_valid = 1'b0;
    check("second.rf_we", 32'(bus.rf_we), 32'd1);
    check("second.rf_wa", 32'(bus.rf_wa), 32'd9);
    check("second.rf_wd", bus.rf_wd,      32'h22);
    @(posedge clk);
    #1;
    check("drain.fwd_valid", 32'(bus.fwd_valid), 32'd0);

    // Reset while stalled
    @(negedge clk);
    drive(1, 0, 5'd7, 32'h0000_0077, 32'h0, LT_LW);
    bus.rf_wr_ready = 1'b0;
    bus.mem_valid   = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_valid = 1'b0;
    @(negedge clk);
    check("pre_rst.fwd_valid", 32'(bus.fwd_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("mid_rst");
    bus.rf_wr_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("post_rst%0d.rf_we", c),     32'(bus.rf_we),     32'd0);
      check($sformatf("post_rst%0d.mem_ready", c), 32'(bus.mem_ready), 32'd1);
    end

`ifdef MIPS_WB_RETIRE_CNT_EN
    // 4-bit counter instance: 10 back-to-back (one misaligned), then 6 more wraps to 0
    check("cnt.reset", 32'(retire_cnt), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 4) drive(1, 1, 5'd5, 32'h0000_1002, 32'h1234_5678, LT_LW);
      else        drive(1, 0, 5'(i + 1), 32'(i), 32'h0, LT_LW);
      bus.mem_valid = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    bus.mem_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("cnt.ten", 32'(retire_cnt), 32'd10);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(1, 0, 5'd0, 32'(i), 32'h0, LT_LW);
      bus.mem_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.mem_valid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check("cnt.wrap", 32'(retire_cnt), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
